// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------
// ctrl_pkg : shared types and constants for the multicycle control unit
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package ctrl_pkg;

  typedef enum logic [7:0] {
    S_RST      = 8'd0,
    S_FETCH    = 8'd1,
    S_MWAIT    = 8'd2,
    S_DECODE   = 8'd3,
    S_R_EXEC   = 8'd4,
    S_R_WB     = 8'd5,
    S_MEM_ADDR = 8'd6,
    S_LW_RD    = 8'd7,
    S_LW_WAIT  = 8'd8,
    S_LW_WB    = 8'd9,
    S_SW_WR    = 8'd10,
    S_SW_WAIT  = 8'd11,
    S_BEQ      = 8'd12,
    S_BNE      = 8'd13,
    S_LUI      = 8'd14,
    S_J        = 8'd15,
    S_EXC      = 8'd16,
    S_HALT     = 8'd17
  } state_e;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_LUI   = 6'h0f,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2b
  } op_e;

  typedef enum logic [5:0] {
    FN_NOP   = 6'h00,
    FN_BREAK = 6'h0d,
    FN_ADD   = 6'h20,
    FN_SUB   = 6'h22,
    FN_AND   = 6'h24,
    FN_XOR   = 6'h26
  } funct_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_IMM = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_EXC    = 2'b11;

  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

  localparam logic CAUSE_OVF = 1'b0;
  localparam logic CAUSE_ILL = 1'b1;

  function automatic logic [2:0] alu_from_funct(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_XOR:  return ALU_XOR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_counter.sv
// ---------------------------------------------------------------
// mem_wait_counter : down-counter timing the memory wait states
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module mem_wait_counter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'((MEM_LATENCY > 0) ? (MEM_LATENCY - 1) : 0);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LOAD_VAL;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------
// mc_control_unit : Moore FSM sequencing a multicycle MIPS datapath
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module mc_control_unit
  import ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter bit EXC_EN      = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       ALU_zero,
  input  logic       ALU_overflow,
  output logic [7:0] StateOut,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNeg,
  output logic       PC_load,
  output logic       wr,
  output logic       IorD,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALU_sel,
  output logic [1:0] MemtoReg,
  output logic [1:0] PCSource,
  output logic       IR_load,
  output logic       MDR_load,
  output logic       A_load,
  output logic       B_load,
  output logic       ALUOut_load,
  output logic       RegWrite,
  output logic       RegReset,
  output logic       PC_reset,
  output logic       EPCWrite,
  output logic       CauseWrite,
  output logic       Cause,
  output logic       Halted
);

  localparam bit NO_WAIT = (MEM_LATENCY == 0);

  state_e state_q, state_d;
  logic   cause_q, cause_d;
  logic   illegal;
  logic   wait_load, wait_dec, wait_done;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_RST;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    illegal        = 1'b0;
    PCWrite        = 1'b0;
    PCWriteCond    = 1'b0;
    PCWriteCondNeg = 1'b0;
    wr             = 1'b0;
    IorD           = 1'b0;
    RegDst         = 1'b0;
    ALUSrcA        = 1'b0;
    ALUSrcB        = SRCB_B;
    ALU_sel        = ALU_AND;
    MemtoReg       = M2R_ALU;
    PCSource       = PCS_ALU;
    IR_load        = 1'b0;
    MDR_load       = 1'b0;
    A_load         = 1'b0;
    B_load         = 1'b0;
    ALUOut_load    = 1'b0;
    RegWrite       = 1'b0;
    RegReset       = 1'b0;
    PC_reset       = 1'b0;
    EPCWrite       = 1'b0;
    CauseWrite     = 1'b0;
    Halted         = 1'b0;

    case (state_q)
      S_RST: begin
        RegReset = 1'b1;
        PC_reset = 1'b1;
        state_d  = S_FETCH;
      end
      S_FETCH: begin
        ALUSrcB = SRCB_4;
        ALU_sel = ALU_ADD;
        PCWrite = 1'b1;
        state_d = NO_WAIT ? S_DECODE : S_MWAIT;
      end
      S_MWAIT: begin
        IR_load  = 1'b1;
        MDR_load = 1'b1;
        if (wait_done) state_d = S_DECODE;
      end
      S_DECODE: begin
        A_load      = 1'b1;
        B_load      = 1'b1;
        ALUOut_load = 1'b1;
        ALUSrcB     = SRCB_IMM_SH;
        ALU_sel     = ALU_ADD;
        case (Op)
          OP_RTYPE: begin
            if (Funct == FN_BREAK) begin
              state_d = S_HALT;
            end else if ((Funct == FN_NOP) || (Funct == FN_ADD) || (Funct == FN_SUB) ||
                         (Funct == FN_AND) || (Funct == FN_XOR)) begin
              state_d = S_R_EXEC;
            end else begin
              illegal = 1'b1;
            end
          end
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BEQ;
          OP_BNE:       state_d = S_BNE;
          OP_LUI:       state_d = S_LUI;
          OP_J:         state_d = S_J;
          default:      illegal = 1'b1;
        endcase
        // Without traps an unknown instruction simply retires as a no-op.
        if (illegal) begin
          if (EXC_EN) begin
            state_d = S_EXC;
            cause_d = CAUSE_ILL;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_R_EXEC: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_B;
        ALU_sel     = alu_from_funct(Funct);
        ALUOut_load = 1'b1;
        if (Funct == FN_NOP) begin
          state_d = S_FETCH;
        end else if (EXC_EN && ALU_overflow && ((Funct == FN_ADD) || (Funct == FN_SUB))) begin
          state_d = S_EXC;
          cause_d = CAUSE_OVF;
        end else begin
          state_d = S_R_WB;
        end
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_ADDR: begin
        // Effective address is base register A plus the sign-extended offset.
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALU_sel     = ALU_ADD;
        ALUOut_load = 1'b1;
        state_d     = (Op == OP_SW) ? S_SW_WR : S_LW_RD;
      end
      S_LW_RD: begin
        IorD    = 1'b1;
        state_d = NO_WAIT ? S_LW_WB : S_LW_WAIT;
      end
      S_LW_WAIT: begin
        IorD     = 1'b1;
        MDR_load = 1'b1;
        if (wait_done) state_d = S_LW_WB;
      end
      S_LW_WB: begin
        MemtoReg = M2R_MDR;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_SW_WR: begin
        IorD    = 1'b1;
        wr      = 1'b1;
        state_d = NO_WAIT ? S_FETCH : S_SW_WAIT;
      end
      S_SW_WAIT: begin
        IorD = 1'b1;
        wr   = 1'b1;
        if (wait_done) state_d = S_FETCH;
      end
      S_BEQ, S_BNE: begin
        ALUSrcA        = 1'b1;
        ALU_sel        = ALU_SUB;
        PCSource       = PCS_ALUOUT;
        PCWriteCond    = (state_q == S_BEQ);
        PCWriteCondNeg = (state_q == S_BNE);
        state_d        = S_FETCH;
      end
      S_LUI: begin
        MemtoReg = M2R_IMM;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_J: begin
        PCSource = PCS_JUMP;
        PCWrite  = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXC: begin
        EPCWrite   = 1'b1;
        CauseWrite = 1'b1;
        PCSource   = PCS_EXC;
        PCWrite    = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        Halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_RST;
    endcase
  end

  // Wait states never follow one another, so entry is a change into one.
  assign wait_load = (state_d inside {S_MWAIT, S_LW_WAIT, S_SW_WAIT}) &&
                     !(state_q inside {S_MWAIT, S_LW_WAIT, S_SW_WAIT});
  assign wait_dec  = (state_q inside {S_MWAIT, S_LW_WAIT, S_SW_WAIT}) && !wait_done;

  mem_wait_counter #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_wait_cnt (
    .Clk    (Clk),
    .Reset  (Reset),
    .load_i (wait_load),
    .dec_i  (wait_dec),
    .done_o (wait_done)
  );

  assign StateOut = state_q;
  assign Cause    = (state_q == S_EXC) ? cause_q : 1'b0;
  assign PC_load  = PCWrite | (PCWriteCond & ALU_zero) | (PCWriteCondNeg & ~ALU_zero);

endmodule

`default_nettype wire
